// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, 8 data bits LSB-first, optional even parity,
// one stop bit. A byte is taken over a valid/ready handshake while idle; every output is a flop.
module serial_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  // Baud counter width: clog2 of the divider, never narrower than one bit.
  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_div
    $error("serial_frame_tx: CLKS_PER_BIT out of range 2..65535");
  end
  if (PARITY_EN > 1) begin : g_bad_par
    $error("serial_frame_tx: PARITY_EN must be 0 or 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      data_q, data_d;
  logic            parity_q, parity_d;
  logic            tx_q, tx_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            cnt_last;

  assign cnt_last = (cnt_q == CntLast);

  // Next-state logic: sequencing of the frame and baud counting.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    parity_d  = parity_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // ready_q is high throughout idle, so valid alone marks acceptance here.
        if (valid_i) begin
          data_d    = data_i;
          parity_d  = ^data_i;
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_last) begin
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so the line level is registered with no extra latency.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = (state_d == StIdle);
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = data_d[bit_idx_d];
      StParity: tx_d = parity_d;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // State and output registers; reset returns the line to idle level at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign tx_o    = tx_q;
  assign ready_o = ready_q;
  assign busy_o  = ~ready_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (parity off / on) at 4 clocks per bit, a frame-level
// reference model checked every cycle, plus literal waveform expectations for directed cases.
module tb_serial_frame_tx;

  localparam int C = 4;

  logic       clk;
  logic       rst_ni;
  logic       valid  [2];
  logic [7:0] data   [2];
  logic       tx_w   [2];
  logic       rdy_w  [2];
  logic       busy_w [2];
  logic       done_w [2];

  int checks = 0;
  int errors = 0;

  serial_frame_tx #(.CLKS_PER_BIT(C), .PARITY_EN(0)) u_dut0 (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .data_i (data[0]),
    .valid_i(valid[0]),
    .ready_o(rdy_w[0]),
    .tx_o   (tx_w[0]),
    .busy_o (busy_w[0]),
    .done_o (done_w[0])
  );

  serial_frame_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1)) u_dut1 (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .data_i (data[1]),
    .valid_i(valid[1]),
    .ready_o(rdy_w[1]),
    .tx_o   (tx_w[1]),
    .busy_o (busy_w[1]),
    .done_o (done_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of line levels, each held C cycles.
  function automatic logic [10:0] build_frame(input logic [7:0] b, input bit par);
    if (par) return {1'b1, ^b, b, 1'b0};
    return {2'b11, b, 1'b0};
  endfunction

  logic        m_busy [2];
  int          m_pos  [2];
  logic        m_done [2];
  logic [10:0] m_bits [2];

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int d = 0; d < 2; d++) begin
        m_busy[d] <= 1'b0;
        m_pos[d]  <= 0;
        m_done[d] <= 1'b0;
        m_bits[d] <= '1;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_busy[d]) begin
          if (m_pos[d] == (10 + d) * C - 1) begin
            m_busy[d] <= 1'b0;
            m_done[d] <= 1'b1;
          end else begin
            m_pos[d] <= m_pos[d] + 1;
          end
        end else begin
          m_done[d] <= 1'b0;
          if (valid[d]) begin
            m_busy[d] <= 1'b1;
            m_pos[d]  <= 0;
            m_bits[d] <= build_frame(data[d], d == 1);
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_ni) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("model_tx%0d", d), 32'(tx_w[d]),
            32'(m_busy[d] ? m_bits[d][m_pos[d] / C] : 1'b1));
        chk($sformatf("model_ready%0d", d), 32'(rdy_w[d]), 32'(!m_busy[d]));
        chk($sformatf("model_busy%0d", d), 32'(busy_w[d]), 32'(m_busy[d]));
        chk($sformatf("model_done%0d", d), 32'(done_w[d]), 32'(m_done[d]));
      end
    end
  end

  logic cap_tx   [64];
  logic cap_done [64];
  logic cap_rdy  [64];

  // Offer one byte while idle and record n cycles after the acceptance edge; DataIn is scrambled
  // after acceptance to show it has no effect on the frame.
  task automatic send_capture(input int d, input logic [7:0] b, input int n);
    @(negedge clk);
    valid[d] = 1'b1;
    data[d]  = b;
    @(posedge clk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) valid[d] = 1'b0;
      data[d]     = 8'($urandom);
      cap_tx[i]   = tx_w[d];
      cap_done[i] = done_w[d];
      cap_rdy[i]  = rdy_w[d];
    end
  endtask

  task automatic check_frame(input string nm, input logic [10:0] exp_bits, input int nbits);
    for (int k = 0; k < nbits * C; k++) begin
      chk($sformatf("%s_bit%0d", nm, k), 32'(cap_tx[k]), 32'(exp_bits[k / C]));
    end
  endtask

  initial begin
    int t_idle;
    int t_busy;
    int n_done;

    rst_ni = 1'b0;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0;
      data[d]  = 8'h00;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("reset_tx", 32'(tx_w[d]), 32'd1);
      chk("reset_ready", 32'(rdy_w[d]), 32'd1);
      chk("reset_busy", 32'(busy_w[d]), 32'd0);
      chk("reset_done", 32'(done_w[d]), 32'd0);
    end
    #10 rst_ni = 1'b1;

    // Idle with Valid low.
    repeat (50) @(negedge clk);
    chk("idle_tx", 32'(tx_w[0]), 32'd1);
    chk("idle_ready", 32'(rdy_w[0]), 32'd1);

    // Single byte, no parity.
    send_capture(0, 8'hA5, 42);
    check_frame("a5", {1'b1, 8'hA5, 1'b0}, 10);
    chk("a5_ready_c40", 32'(cap_rdy[39]), 32'd0);
    chk("a5_done_c40", 32'(cap_done[39]), 32'd0);
    chk("a5_done_c41", 32'(cap_done[40]), 32'd1);
    chk("a5_ready_c41", 32'(cap_rdy[40]), 32'd1);
    chk("a5_done_c42", 32'(cap_done[41]), 32'd0);

    // Parity on: 8'h07 has odd weight so the parity bit is 1; 8'h03 gives 0.
    send_capture(1, 8'h07, 46);
    check_frame("p07", {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    chk("p07_parity", 32'(cap_tx[36]), 32'd1);
    chk("p07_done_c44", 32'(cap_done[43]), 32'd0);
    chk("p07_done_c45", 32'(cap_done[44]), 32'd1);
    send_capture(1, 8'h03, 46);
    chk("p03_parity", 32'(cap_tx[36]), 32'd0);
    chk("p03_done_c45", 32'(cap_done[44]), 32'd1);

    // Back-to-back with Valid held high: 8'h55 then 8'hAA.
    @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 8'h55;
    @(posedge clk);
    @(negedge clk);
    data[0] = 8'hAA;
    t_idle = -1;
    t_busy = -1;
    for (int k = 2; k <= 100 && t_busy < 0; k++) begin
      @(negedge clk);
      if (!busy_w[0] && t_idle < 0) t_idle = k;
      if (busy_w[0] && t_idle >= 0) t_busy = k;
    end
    valid[0] = 1'b0;
    chk("b2b_idle_cycle", 32'(t_idle), 32'd41);
    chk("b2b_next_accept", 32'(t_busy), 32'd42);
    repeat (50) @(negedge clk);

    // Valid while busy is dropped.
    @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 8'h81;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (12) @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 8'hFF;
    @(negedge clk);
    valid[0] = 1'b0;
    n_done = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done_w[0]) n_done++;
    end
    chk("ignored_done_count", 32'(n_done), 32'd1);
    chk("ignored_busy_after", 32'(busy_w[0]), 32'd0);

    // Reset during data bit 3 (cycles 17..20 after acceptance).
    @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    #1 rst_ni = 1'b0;
    #1;
    chk("midreset_tx", 32'(tx_w[0]), 32'd1);
    chk("midreset_ready", 32'(rdy_w[0]), 32'd1);
    chk("midreset_busy", 32'(busy_w[0]), 32'd0);
    chk("midreset_done", 32'(done_w[0]), 32'd0);
    @(negedge clk);
    #2 rst_ni = 1'b1;
    send_capture(0, 8'h3C, 42);
    check_frame("x3c", {1'b1, 8'h3C, 1'b0}, 10);
    chk("x3c_done_c41", 32'(cap_done[40]), 32'd1);

    // Randomized traffic on both instances, checked by the model every cycle.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        valid[d] = ($urandom_range(0, 7) == 0);
        data[d]  = 8'($urandom);
      end
    end
    for (int d = 0; d < 2; d++) valid[d] = 1'b0;
    repeat (60) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Parallel-to-serial frame transmitter for 8-bit data, the stage downstream of the byte-wide shift register datapath. It accepts a byte over a valid/ready handshake and transmits an asynchronous serial frame: one start bit, 8 data bits LSB-first, an optional even-parity bit, and one stop bit, at a rate set by a clock divider. It drives the serial line of the design's output link and returns to idle line level between frames.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
- PARITY_EN, default 0: 1 inserts an even-parity bit between the data bits and the stop bit.

Ports:
- Clk  input  1  single clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset. Reset=0 forces reset state immediately, regardless of Clk.
- DataIn  input  8  byte to transmit; sampled only on the acceptance edge.
- Valid  input  1  DataIn holds a byte to send.
- Ready  output  1  block can accept a byte; high only in IDLE.
- TxOut  output  1  serial line; idle level is 1.
- Busy  output  1  frame in progress; equals ~Ready.
- Done  output  1  one-cycle pulse when a frame completes.

## Operation
- Reset values: TxOut=1, Ready=1, Busy=0, Done=0, state=IDLE, baud counter=0, bit index=0, data latch=0.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- IDLE: TxOut=1. Acceptance occurs on a rising edge with Valid=1 and Ready=1. At that edge the block latches DataIn, computes the parity (XOR of all 8 bits), clears the baud counter, and enters START.
- START: TxOut=0 for CLKS_PER_BIT cycles.
- DATA: TxOut=latch[bit index], starting at bit 0. Each bit lasts CLKS_PER_BIT cycles. The bit index increments modulo 8. After bit 7 the block moves to PARITY, or to STOP when PARITY_EN=0.
- PARITY: TxOut=XOR of the 8 data bits (even parity), for CLKS_PER_BIT cycles.
- STOP: TxOut=1 for CLKS_PER_BIT cycles, then the block enters IDLE.
- Done=1 for exactly one cycle: the first IDLE cycle after STOP, which is the same cycle Ready rises.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Width is clog2(CLKS_PER_BIT), minimum 1.
  - On reaching CLKS_PER_BIT-1 it wraps to 0 and advances the state or bit.
- Boundary conditions:
  - Valid while Busy: ignored; the byte is not queued.
  - DataIn changes after acceptance: no effect on the current frame.
  - Valid held high continuously: frames go back-to-back. The next byte is accepted on the edge that ends the Done cycle, so there is one idle-level cycle between frames.
  - Reset asserted mid-frame: TxOut returns to 1 at once, the frame is aborted, and no Done pulse is issued.
  - Reset released: the block operates from the first rising edge of Clk with Reset=1.

## Timing
- Frame length, from the acceptance edge to the edge entering IDLE: (10+PARITY_EN)*CLKS_PER_BIT cycles.
- TxOut falls 1 cycle after the acceptance edge (registered output); it is the value after that edge.
- All outputs are registered and glitch-free; TxOut is driven directly from a flop.
- Ready is low from the acceptance edge until the edge that enters IDLE.
- Throughput with Valid held high: one byte per (10+PARITY_EN)*CLKS_PER_BIT+1 cycles.

## Test plan
- Reset then idle, with CLKS_PER_BIT=4 and Valid=0 for 50 cycles -> TxOut=1, Ready=1, Busy=0, Done=0 throughout.
- Single byte, CLKS_PER_BIT=4, PARITY_EN=0, DataIn=8'hA5 accepted -> TxOut over 40 cycles is 0, then 1,0,1,0,0,1,0,1 (LSB-first), then 1, with each level held 4 cycles. Done pulses once at cycle 41 and Ready=1 at cycle 41.
- Parity on, PARITY_EN=1, DataIn=8'h07 -> parity bit=1 and frame length 44 cycles at CLKS_PER_BIT=4. With DataIn=8'h03 -> parity bit=0.
- Back-to-back with Valid held high: send 8'h55 then 8'hAA -> two complete frames separated by exactly one idle cycle. DataIn changes during the first frame do not alter it.
- Ignored Valid: pulse Valid with 8'hFF during the DATA state -> no change in the current frame and no second frame.
- Reset mid-frame: assert Reset during data bit 3 -> TxOut=1 and Ready=1 immediately, without waiting for a clock edge, and no Done. A subsequent byte 8'h3C transmits correctly.
